// File: rtl/sprite_anim.sv
// sprite_anim -- parametrised animated-sprite engine.
//
// Takes the VGA scan position and the sprite state (position, facing, action).
// It produces a sprite-sheet ROM address, then returns a latency-aligned
// pixel colour and hit flag to the pixel mux.
//
// The sprite state is latched only on frame_tick, so a sprite never tears
// mid-frame. A divider slows anim_tick down to the frame-step rate. Each
// action either loops over its frames or plays once and holds its last frame.
//
// Ports:
//   clk, rst            pixel clock; synchronous active-high reset
//   frame_tick          one-cycle pulse at start of vblank (state latch point)
//   anim_tick           one-cycle animation-rate pulse
//   col, row            current scan position
//   pos_x, pos_y        sprite top-left (live; shadowed on frame_tick)
//   dir                 1 = native orientation, 0 = horizontally mirrored
//   action              action select; out-of-range values map to action 0
//   rom_addr            registered sprite-sheet address, 0 outside the sprite
//   rom_data            ROM read data, ROM_LAT cycles after rom_addr
//   is_spr, spr_rgb     opaque-pixel flag and colour, ROM_LAT+2 cycles after col/row
//   frame_idx           current animation frame
//   anim_done           one-shot action has reached its last frame
//   ctr_x, ctr_y        sprite centre from the latched position
module sprite_anim #(
  parameter int          SPR_W        = 31,
  parameter int          SPR_H        = 23,
  parameter int          N_FRAMES     = 4,
  parameter int          N_ACTIONS    = 4,
  parameter int          TICK_DIV     = 1,
  parameter logic [3:0]  ONESHOT_MASK = 4'b0000,
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] KEY_COLOR    = 12'hFFF,
  parameter int          ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              anim_tick,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              dir,
  input  logic [1:0]        action,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              is_spr,
  output logic [11:0]       spr_rgb,
  output logic [1:0]        frame_idx,
  output logic              anim_done,
  output logic [9:0]        ctr_x,
  output logic [9:0]        ctr_y
);

  localparam int         DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] LAST_FRAME = 2'(N_FRAMES - 1);

  // Shadow copies of the sprite state; all address math uses these.
  logic [9:0]       sh_x;
  logic [9:0]       sh_y;
  logic             sh_dir;
  logic [1:0]       sh_act;

  logic [1:0]       frame;
  logic [DIV_W-1:0] div;
  logic             done_q;

  logic [1:0]       act_in;
  logic             act_change;
  logic             div_wrap;
  logic             is_oneshot;
  logic [1:0]       frame_adv;

  assign act_in     = (int'(action) < N_ACTIONS) ? action : 2'd0;
  assign act_change = frame_tick && (act_in != sh_act);
  assign div_wrap   = (div == DIV_W'(TICK_DIV - 1));
  assign is_oneshot = ONESHOT_MASK[sh_act];
  // A one-shot action saturates on its last frame; a loop action wraps to 0.
  assign frame_adv  = (frame == LAST_FRAME) ? (is_oneshot ? LAST_FRAME : 2'd0)
                                            : frame + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_dir <= 1'b0;
      sh_act <= '0;
      ctr_x  <= '0;
      ctr_y  <= '0;
      frame  <= '0;
      div    <= '0;
      done_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        sh_x   <= pos_x;
        sh_y   <= pos_y;
        sh_dir <= dir;
        sh_act <= act_in;
        ctr_x  <= pos_x + 10'(SPR_W / 2);
        ctr_y  <= pos_y + 10'(SPR_H / 2);
      end
      // An action change restarts the animation and swallows a coincident tick.
      if (act_change) begin
        frame  <= '0;
        div    <= '0;
        done_q <= 1'b0;
      end else if (anim_tick) begin
        if (div_wrap) begin
          div   <= '0;
          frame <= frame_adv;
          if (is_oneshot && (frame_adv == LAST_FRAME))
            done_q <= 1'b1;
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

  assign frame_idx = frame;
  assign anim_done = done_q;

  // Hit test: the col >= x check rejects the 10-bit wrap of col - x.
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [9:0]        ax;
  logic              in_box;
  logic [ADDR_W-1:0] addr_calc;

  assign dx     = col - sh_x;
  assign dy     = row - sh_y;
  assign in_box = (col >= sh_x) && (dx < 10'(SPR_W)) &&
                  (row >= sh_y) && (dy < 10'(SPR_H));
  assign ax     = sh_dir ? dx : (10'(SPR_W - 1) - dx);
  // Sheet layout: action-major, then frame, then row, then column.
  assign addr_calc = ADDR_W'(((32'(sh_act) * N_FRAMES + 32'(frame)) * SPR_H
                              + 32'(dy)) * SPR_W + 32'(ax));

  // in_box_sr[ROM_LAT] lines up with rom_data for the same scan position.
  logic [ROM_LAT:0] in_box_sr;
  logic             is_spr_next;

  assign is_spr_next = in_box_sr[ROM_LAT] && (rom_data != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      in_box_sr <= '0;
      is_spr    <= 1'b0;
      spr_rgb   <= '0;
    end else begin
      rom_addr  <= in_box ? addr_calc : '0;
      in_box_sr <= {in_box_sr[ROM_LAT-1:0], in_box};
      is_spr    <= is_spr_next;
      spr_rgb   <= is_spr_next ? rom_data : 12'h000;
    end
  end

endmodule

// File: tb/tb_sprite_anim.sv
// tb_sprite_anim -- directed bench for sprite_anim (TICK_DIV=2, action 2 one-shot).
module tb_sprite_anim;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        anim_tick;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        dir;
  logic [1:0]  action;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic        is_spr;
  logic [11:0] spr_rgb;
  logic [1:0]  frame_idx;
  logic        anim_done;
  logic [9:0]  ctr_x;
  logic [9:0]  ctr_y;

  sprite_anim #(
    .TICK_DIV     (2),
    .ONESHOT_MASK (4'b0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .anim_tick  (anim_tick),
    .col        (col),
    .row        (row),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .action     (action),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .is_spr     (is_spr),
    .spr_rgb    (spr_rgb),
    .frame_idx  (frame_idx),
    .anim_done  (anim_done),
    .ctr_x      (ctr_x),
    .ctr_y      (ctr_y)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // Sprite-sheet ROM contents: every fifth address is transparent.
  function automatic logic [11:0] rom_val(input logic [13:0] a);
    if (a % 5 == 3)            return 12'hFFF;
    else if (a[11:0] == 12'hFFF) return 12'h123;
    else                       return a[11:0];
  endfunction

  // One-cycle-latency ROM.
  always @(posedge clk) rom_data <= rom_val(rom_addr);

  // ---- scoreboard ----
  int n_vec = 0;
  int n_bad = 0;
  logic [12:0] exp_q[$];   // {is_spr, spr_rgb} expected 2 cycles after stage 0

  // Bench view of the latched sprite state.
  int bx = 0, by = 0, bdir = 0, bact = 0, bframe = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    col = 10'd1023;
    row = 10'd1023;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync_q();
    exp_q.delete();
    exp_q.push_back(13'h0);
    exp_q.push_back(13'h0);
  endtask

  task automatic latch_state(input int x, input int y, input int d, input int a);
    pos_x = 10'(x);
    pos_y = 10'(y);
    dir = d[0];
    action = 2'(a);
    col = 10'd1023;
    row = 10'd1023;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (a != bact) bframe = 0;
    bx = x; by = y; bdir = d; bact = a;
  endtask

  task automatic anim_pulse();
    anim_tick = 1'b1;
    step();
    anim_tick = 1'b0;
  endtask

  // Drive one scan position, check its stage-0 address and the output that
  // belongs to the position two steps earlier.
  task automatic scan_pix(input int c, input int r);
    int dx, dy, ea;
    bit in;
    logic [11:0] v;
    logic [12:0] e;
    col = 10'(c);
    row = 10'(r);
    step();
    dx = c - bx;
    dy = r - by;
    in = (dx >= 0) && (dx < 31) && (dy >= 0) && (dy < 23);
    ea = in ? ((bact * 4 + bframe) * 23 + dy) * 31 + (bdir != 0 ? dx : 30 - dx) : 0;
    check("rom_addr", 32'(rom_addr), 32'(ea));
    v = rom_val(14'(ea));
    exp_q.push_back((in && v != 12'hFFF) ? {1'b1, v} : 13'h0);
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      check("is_spr", 32'(is_spr), 32'(e[12]));
      check("spr_rgb", 32'(spr_rgb), 32'(e[11:0]));
    end
  endtask

  task automatic drain();
    scan_pix(1023, 1023);
    scan_pix(1023, 1023);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 0);
    check({tag, "_is_spr"}, 32'(is_spr), 0);
    check({tag, "_spr_rgb"}, 32'(spr_rgb), 0);
    check({tag, "_frame_idx"}, 32'(frame_idx), 0);
    check({tag, "_anim_done"}, 32'(anim_done), 0);
    check({tag, "_ctr_x"}, 32'(ctr_x), 0);
    check({tag, "_ctr_y"}, 32'(ctr_y), 0);
  endtask

  logic [1:0] loop_seq [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    anim_tick = 1'b0;
    col = 10'd1023;
    row = 10'd1023;
    pos_x = '0;
    pos_y = '0;
    dir = 1'b0;
    action = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) step();
    check_all_zero("reset");
    rst = 1'b0;

    // Native orientation sweep across the top row.
    latch_state(100, 50, 1, 0);
    check("ctr_x_115", 32'(ctr_x), 115);
    check("ctr_y_61", 32'(ctr_y), 61);
    idle(2);
    sync_q();
    for (int c = 98; c <= 132; c++) begin
      scan_pix(c, 50);
      if (c == 99)  check("dir1_c99", 32'(rom_addr), 0);
      if (c == 130) check("dir1_c130", 32'(rom_addr), 30);
    end
    drain();

    // Mirrored sweep plus a wrap probe left of the sprite.
    latch_state(100, 50, 0, 0);
    idle(2);
    sync_q();
    for (int c = 98; c <= 132; c++) begin
      scan_pix(c, 50);
      if (c == 100) check("dir0_c100", 32'(rom_addr), 30);
      if (c == 130) check("dir0_c130", 32'(rom_addr), 0);
    end
    scan_pix(5, 50);
    check("wrap_c5", 32'(rom_addr), 0);
    drain();

    // Looping action 1 with a divide-by-2 frame step.
    latch_state(100, 50, 1, 1);
    idle(2);
    sync_q();
    scan_pix(100, 51);
    check("act1_f0_addr", 32'(rom_addr), 2883);
    drain();
    for (int i = 0; i < 10; i++) begin
      check("loop_frame", 32'(frame_idx), 32'(loop_seq[i]));
      anim_pulse();
    end
    check("loop_frame_end", 32'(frame_idx), 1);
    bframe = 1;
    idle(2);
    sync_q();
    scan_pix(100, 51);
    check("act1_f1_addr", 32'(rom_addr), 3596);
    drain();

    // One-shot action 2: holds frame 3 and raises anim_done.
    latch_state(100, 50, 1, 2);
    check("os_start_frame", 32'(frame_idx), 0);
    for (int i = 0; i < 4; i++) anim_pulse();
    check("os_frame2", 32'(frame_idx), 2);
    check("os_done_early", 32'(anim_done), 0);
    for (int i = 0; i < 8; i++) anim_pulse();
    check("os_frame_hold", 32'(frame_idx), 3);
    check("os_done", 32'(anim_done), 1);

    // Action change with a coincident anim_tick: restart wins.
    action = 2'd1;
    frame_tick = 1'b1;
    anim_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    anim_tick = 1'b0;
    bact = 1;
    bframe = 0;
    check("chg_frame", 32'(frame_idx), 0);
    check("chg_done", 32'(anim_done), 0);
    anim_pulse();
    check("chg_div_frame", 32'(frame_idx), 0);
    anim_pulse();
    check("chg_step_frame", 32'(frame_idx), 1);
    bframe = 1;

    // pos_x moves without frame_tick: address keeps using the latched x.
    pos_x = 10'd200;
    idle(2);
    sync_q();
    scan_pix(100, 50);
    check("no_tear_addr", 32'(rom_addr), 3565);
    drain();
    latch_state(200, 50, 1, 1);
    check("ctr_x_215", 32'(ctr_x), 215);
    check("ctr_y_61b", 32'(ctr_y), 61);
    idle(2);
    sync_q();
    scan_pix(200, 50);
    check("new_x_addr", 32'(rom_addr), 3565);
    scan_pix(100, 50);
    check("old_x_addr", 32'(rom_addr), 0);
    drain();

    // One-cycle reset in the middle of the sprite.
    idle(2);
    sync_q();
    for (int c = 200; c <= 203; c++) scan_pix(c, 50);
    col = 10'd204;
    row = 10'd50;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    bx = 0; by = 0; bdir = 0; bact = 0; bframe = 0;
    latch_state(200, 50, 1, 1);
    sync_q();
    for (int c = 200; c <= 205; c++) begin
      scan_pix(c, 50);
      if (c == 200) check("rst_resume_addr", 32'(rom_addr), 2852);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
